// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : state encodings, tick-counter sizing and parity helper shared by
//            the uart_cosim_bridge files
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  function automatic int tick_width(input int ticks);
    return (ticks <= 2) ? 1 : $clog2(ticks);
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] bits);
    return ^bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cosim_bridge_if.sv
`default_nettype none
// ============================================================================
// uart_cosim_bridge_if : bench-side byte stream of the UART cosim bridge
// Revision : 1.0
// ============================================================================
interface uart_cosim_bridge_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_overflow;
  logic                 rx_frame_error;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_overflow, rx_frame_error
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_overflow, rx_frame_error
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : first-word fall-through FIFO with registered overflow pulse
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             overflow
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  // Extra MSB on each pointer separates full from empty when indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      overflow <= push && full && !do_pop;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign not_empty = !empty;

endmodule
`default_nettype wire

// File: rtl/uart_cosim_bridge.sv
`default_nettype none
// ============================================================================
// uart_cosim_bridge : RTL UART endpoint for cosim; TX/RX FSMs + RX FIFO.
//                     Define UART_PARITY_EN for an even parity bit both ways.
// Revision          : 1.0
// ============================================================================
module uart_cosim_bridge
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BAUD = 4,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int RX_FIFO_DEPTH  = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  uart_cosim_bridge_if.slave bus,
  output logic               serial_out,
  input  logic               serial_in,
  output logic               uart_sampling,
  output logic [7:0]         uart_ticks_counter,
  output logic [31:0]        uart_ticks_per_baud
);

  generate
    if (TICKS_PER_BAUD < 2 || TICKS_PER_BAUD > 256) begin : g_bad_ticks
      $error("uart_cosim_bridge: TICKS_PER_BAUD must be 2..256");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_cosim_bridge: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_cosim_bridge: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int            TW        = tick_width(TICKS_PER_BAUD);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BAUD - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(TICKS_PER_BAUD / 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t            tx_state;
  logic [TW-1:0]        tx_tick;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_ready_q;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state   <= TX_IDLE;
      tx_tick    <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      tx_ready_q <= 1'b1;
      serial_out <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.tx_valid) begin
            tx_state   <= TX_START;
            tx_tick    <= '0;
            tx_shift   <= bus.tx_data;
            tx_ready_q <= 1'b0;
            serial_out <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par     <= even_parity(MAX_DATA_BITS'(bus.tx_data));
`endif
          end
        end
        TX_START: begin
          tx_tick <= tx_tick + TW'(1);
          if (tx_tick == TICK_LAST) begin
            tx_tick    <= '0;
            tx_bit     <= '0;
            tx_state   <= TX_DATA;
            serial_out <= tx_shift[0];
          end
        end
        TX_DATA: begin
          tx_tick <= tx_tick + TW'(1);
          if (tx_tick == TICK_LAST) begin
            tx_tick <= '0;
            if (tx_bit == DATA_LAST) begin
              tx_bit     <= '0;
`ifdef UART_PARITY_EN
              tx_state   <= TX_PARITY;
              serial_out <= tx_par;
`else
              tx_state   <= TX_STOP;
              serial_out <= 1'b1;
`endif
            end else begin
              tx_bit     <= tx_bit + 4'd1;
              tx_shift   <= tx_shift >> 1;
              serial_out <= tx_shift[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          tx_tick <= tx_tick + TW'(1);
          if (tx_tick == TICK_LAST) begin
            tx_tick    <= '0;
            tx_state   <= TX_STOP;
            serial_out <= 1'b1;
          end
        end
`endif
        TX_STOP: begin
          tx_tick <= tx_tick + TW'(1);
          if (tx_tick == TICK_LAST) begin
            tx_tick <= '0;
            if (tx_bit == STOP_LAST) begin
              tx_state   <= TX_IDLE;
              tx_ready_q <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 4'd1;
            end
          end
        end
        default: begin
          tx_state   <= TX_IDLE;
          tx_ready_q <= 1'b1;
          serial_out <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_ready = tx_ready_q;

  rx_state_t            rx_state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic [TW-1:0]        rx_tick;
  logic [TW-1:0]        rx_tick_next;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_push;
  logic [DATA_BITS-1:0] rx_push_data;
  logic                 rx_frame_err;
  logic                 parity_ok;
`ifdef UART_PARITY_EN
  logic                 rx_par_bit;
  assign parity_ok = (even_parity(MAX_DATA_BITS'(rx_shift)) == rx_par_bit);
`else
  assign parity_ok = 1'b1;
`endif

  assign rx_tick_next = (rx_tick == TICK_LAST) ? '0 : rx_tick + TW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_tick       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_push       <= 1'b0;
      rx_push_data  <= '0;
      rx_frame_err  <= 1'b0;
      uart_sampling <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bit    <= 1'b0;
`endif
    end else begin
      rx_meta       <= serial_in;
      rx_sync       <= rx_meta;
      uart_sampling <= 1'b0;
      rx_push       <= 1'b0;
      rx_frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_tick <= '0;
          // The detecting cycle counts as tick 0 of the start bit.
          if (!rx_sync) begin
            rx_state <= RX_START;
            rx_tick  <= rx_tick_next;
          end
        end
        RX_START: begin
          rx_tick <= rx_tick_next;
          if (rx_tick == TICK_MID) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
              rx_tick  <= '0;
            end else begin
              rx_state      <= RX_DATA;
              rx_bit        <= '0;
              uart_sampling <= 1'b1;
            end
          end
        end
        RX_DATA: begin
          rx_tick <= rx_tick_next;
          if (rx_tick == TICK_MID) begin
            uart_sampling <= 1'b1;
            rx_shift      <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          rx_tick <= rx_tick_next;
          if (rx_tick == TICK_MID) begin
            uart_sampling <= 1'b1;
            rx_par_bit    <= rx_sync;
            rx_state      <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          rx_tick <= rx_tick_next;
          if (rx_tick == TICK_MID) begin
            uart_sampling <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_tick       <= '0;
            if (rx_sync && parity_ok) begin
              rx_push      <= 1'b1;
              rx_push_data <= rx_shift;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          rx_tick  <= '0;
        end
      endcase
    end
  end

  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_not_empty;
  logic                 fifo_overflow;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (bus.rx_ready),
    .head      (fifo_head),
    .not_empty (fifo_not_empty),
    .overflow  (fifo_overflow)
  );

  assign bus.rx_data          = fifo_head;
  assign bus.rx_valid         = fifo_not_empty;
  assign bus.rx_overflow      = fifo_overflow;
  assign bus.rx_frame_error   = rx_frame_err;
  assign uart_ticks_counter   = 8'(rx_tick);
  assign uart_ticks_per_baud  = 32'(TICKS_PER_BAUD);

endmodule
`default_nettype wire
